// File: rtl/vga_timing_ctrl.sv
// rtl/vga_timing_ctrl.sv - VGA timing sequencer with per-line prefetch handshake
//
// Walks horizontal/vertical position counters through active, front porch,
// sync and back porch phases, and asks the frame-memory reader for each
// visible line one line ahead.
//
// Optional feature macro: VGA_UNDERRUN_BLANK_EN
//   defined     - an underrun line is blanked (oActive forced low for that line)
//   not defined - an underrun line is displayed normally, only oUnderrun is set
//
// Ports:
//   iClk        in   pixel clock, rising edge
//   iRst_n      in   asynchronous active-low reset
//   iEn         in   count enable; low freezes all state and outputs
//   iLineAck    in   reader has buffered the requested line
//   oHSync      out  horizontal sync (polarity from SYNC_POL)
//   oVSync      out  vertical sync (polarity from SYNC_POL)
//   oActive     out  pixel at (oX,oY) is visible
//   oX, oY      out  16-bit position counters
//   oENVCounter out  end-of-line strobe (oX = H_TOTAL-1)
//   oFrameStart out  strobe at position (0,0)
//   oLineReq    out  prefetch request
//   oLineNum    out  line being requested
//   oUnderrun   out  sticky: a visible line started before its ack
module vga_timing_ctrl #(
    parameter int H_ACTIVE = 1920,
    parameter int H_FP     = 88,
    parameter int H_SYNC   = 44,
    parameter int H_BP     = 148,
    parameter int V_ACTIVE = 1080,
    parameter int V_FP     = 4,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 36,
    parameter int SYNC_POL = 1
) (
    input  logic        iClk,
    input  logic        iRst_n,
    input  logic        iEn,
    input  logic        iLineAck,
    output logic        oHSync,
    output logic        oVSync,
    output logic        oActive,
    output logic [15:0] oX,
    output logic [15:0] oY,
    output logic        oENVCounter,
    output logic        oFrameStart,
    output logic        oLineReq,
    output logic [15:0] oLineNum,
    output logic        oUnderrun
);

    localparam logic [15:0] H_ACT_LAST  = 16'(H_ACTIVE - 1);
    localparam logic [15:0] H_FP_LAST   = 16'(H_ACTIVE + H_FP - 1);
    localparam logic [15:0] H_SYNC_LAST = 16'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [15:0] H_LAST      = 16'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [15:0] V_ACT_LAST  = 16'(V_ACTIVE - 1);
    localparam logic [15:0] V_FP_LAST   = 16'(V_ACTIVE + V_FP - 1);
    localparam logic [15:0] V_SYNC_LAST = 16'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [15:0] V_LAST      = 16'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [15:0] V_ACT_N     = 16'(V_ACTIVE);
    localparam logic [15:0] H_ACT_N     = 16'(H_ACTIVE);
    localparam logic        SYNC_ON     = (SYNC_POL != 0);

    typedef enum logic [1:0] {HS_ACT, HS_FP, HS_SYNC, HS_BP} h_state_t;
    typedef enum logic [1:0] {VS_ACT, VS_FP, VS_SYNC, VS_BP} v_state_t;

    h_state_t    r_h_state, w_h_nxt;
    v_state_t    r_v_state, w_v_nxt;
    logic [15:0] r_x, r_y;
    logic [15:0] w_x_nxt, w_y_nxt, w_y_plus;
    logic        w_h_wrap, w_y_last;
    logic        w_req_start, w_stale, w_flag, w_blank_nxt;
    logic        r_hsync, r_vsync, r_active, r_env, r_frame_start;
    logic        r_line_req, r_underrun, r_armed;
    logic [15:0] r_line_num;
`ifdef VGA_UNDERRUN_BLANK_EN
    logic        r_blank;
`endif

    // Next position and phase for the coming enabled clock.
    always_comb begin
        w_h_wrap = (r_x == H_LAST);
        w_y_last = (r_y == V_LAST);
        w_x_nxt  = w_h_wrap ? 16'd0 : r_x + 16'd1;
        w_y_plus = w_y_last ? 16'd0 : r_y + 16'd1;
        w_y_nxt  = w_h_wrap ? w_y_plus : r_y;

        w_h_nxt = r_h_state;
        case (r_h_state)
            HS_ACT:  if (r_x == H_ACT_LAST)  w_h_nxt = HS_FP;
            HS_FP:   if (r_x == H_FP_LAST)   w_h_nxt = HS_SYNC;
            HS_SYNC: if (r_x == H_SYNC_LAST) w_h_nxt = HS_BP;
            HS_BP:   if (w_h_wrap)           w_h_nxt = HS_ACT;
            default:                         w_h_nxt = HS_ACT;
        endcase

        // The vertical machine only moves on the end-of-line clock.
        w_v_nxt = r_v_state;
        if (w_h_wrap) begin
            case (r_v_state)
                VS_ACT:  if (r_y == V_ACT_LAST)  w_v_nxt = VS_FP;
                VS_FP:   if (r_y == V_FP_LAST)   w_v_nxt = VS_SYNC;
                VS_SYNC: if (r_y == V_SYNC_LAST) w_v_nxt = VS_BP;
                VS_BP:   if (w_y_last)           w_v_nxt = VS_ACT;
                default:                         w_v_nxt = VS_ACT;
            endcase
        end

        // Request the following line as the front porch begins.
        w_req_start = (r_h_state == HS_ACT) && (r_x == H_ACT_LAST) && (w_y_plus < V_ACT_N);
        // A request still open when a visible line begins is stale: drop it.
        w_stale = w_h_wrap && (w_y_plus < V_ACT_N) && r_line_req;
        // Flag only once armed; the wrap into (0,0) is itself the arming
        // frame start, so the first frame's line 0 is never covered.
        w_flag = w_stale && (r_armed || (w_y_plus == 16'd0));

`ifdef VGA_UNDERRUN_BLANK_EN
        w_blank_nxt = w_h_wrap ? w_flag : r_blank;
`else
        w_blank_nxt = 1'b0;
`endif
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_h_state <= HS_ACT;
            r_v_state <= VS_ACT;
        end else if (iEn) begin
            r_h_state <= w_h_nxt;
            r_v_state <= w_v_nxt;
        end
    end

    // Outputs are computed from the next position so they line up with oX/oY.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_x           <= 16'd0;
            r_y           <= 16'd0;
            r_hsync       <= ~SYNC_ON;
            r_vsync       <= ~SYNC_ON;
            r_active      <= 1'b0;
            r_env         <= 1'b0;
            r_frame_start <= 1'b0;
            r_line_req    <= 1'b0;
            r_line_num    <= 16'd0;
            r_underrun    <= 1'b0;
            r_armed       <= 1'b0;
        end else if (iEn) begin
            r_x           <= w_x_nxt;
            r_y           <= w_y_nxt;
            r_hsync       <= (w_h_nxt == HS_SYNC) ? SYNC_ON : ~SYNC_ON;
            r_vsync       <= (w_v_nxt == VS_SYNC) ? SYNC_ON : ~SYNC_ON;
            r_active      <= (w_h_nxt == HS_ACT) && (w_v_nxt == VS_ACT) && !w_blank_nxt;
            r_env         <= (w_x_nxt == H_LAST);
            r_frame_start <= (w_x_nxt == 16'd0) && (w_y_nxt == 16'd0);
            if (w_req_start) begin
                r_line_req <= 1'b1;
                r_line_num <= w_y_plus;
            end else if ((r_line_req && iLineAck) || w_stale) begin
                r_line_req <= 1'b0;
            end
            if (w_flag) begin
                r_underrun <= 1'b1;
            end
            if (w_h_wrap && (w_y_plus == 16'd0)) begin
                r_armed <= 1'b1;
            end
        end
    end

`ifdef VGA_UNDERRUN_BLANK_EN
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_blank <= 1'b0;
        end else if (iEn) begin
            r_blank <= w_blank_nxt;
        end
    end
`endif

    assign oHSync      = r_hsync;
    assign oVSync      = r_vsync;
    assign oActive     = r_active;
    assign oX          = r_x;
    assign oY          = r_y;
    assign oENVCounter = r_env;
    assign oFrameStart = r_frame_start;
    assign oLineReq    = r_line_req;
    assign oLineNum    = r_line_num;
    assign oUnderrun   = r_underrun;

    // H_ACT_N is kept for readability of the request timing; tie it off here.
    logic w_unused;
    assign w_unused = ^H_ACT_N;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// tb/tb_vga_timing_ctrl.sv - self-checking bench for vga_timing_ctrl
module tb_vga_timing_ctrl;

    localparam int HA = 8, HF = 2, HS = 2, HB = 2;
    localparam int VA = 4, VF = 1, VS = 1, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
`ifdef VGA_UNDERRUN_BLANK_EN
    localparam bit BLANK_EN = 1'b1;
`else
    localparam bit BLANK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n, en, ack;

    logic        p_hs, p_vs, p_act, p_env, p_fs, p_req, p_und;
    logic [15:0] p_x, p_y, p_ln;
    logic        n_hs, n_vs, n_act, n_env, n_fs, n_req, n_und;
    logic [15:0] n_x, n_y, n_ln;

    vga_timing_ctrl #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1)
    ) dut (
        .iClk(clk), .iRst_n(rst_n), .iEn(en), .iLineAck(ack),
        .oHSync(p_hs), .oVSync(p_vs), .oActive(p_act), .oX(p_x), .oY(p_y),
        .oENVCounter(p_env), .oFrameStart(p_fs), .oLineReq(p_req),
        .oLineNum(p_ln), .oUnderrun(p_und)
    );

    vga_timing_ctrl #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(0)
    ) dut_n (
        .iClk(clk), .iRst_n(rst_n), .iEn(en), .iLineAck(ack),
        .oHSync(n_hs), .oVSync(n_vs), .oActive(n_act), .oX(n_x), .oY(n_y),
        .oENVCounter(n_env), .oFrameStart(n_fs), .oLineReq(n_req),
        .oLineNum(n_ln), .oUnderrun(n_und)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: screen position plus request/underrun bookkeeping.
    int mx, my, mline, mage, mdelay;
    bit mfresh, mreq, mund, marmed, mblank;

    task automatic model_reset();
        mx = 0; my = 0; mline = 0; mage = 0; mdelay = 0;
        mfresh = 1'b1; mreq = 1'b0; mund = 1'b0; marmed = 1'b0; mblank = 1'b0;
    endtask

    task automatic model_step(input bit a);
        bit wrap, stale, und_now;
        int nx, ny, nl;
        wrap = (mx == HT - 1);
        nx = wrap ? 0 : mx + 1;
        ny = wrap ? (my + 1) % VT : my;
        nl = (my + 1) % VT;
        stale = wrap && (ny < VA) && mreq;
        und_now = stale && (marmed || ny == 0);
        if (und_now) mund = 1'b1;
        if (nx == HA && nl < VA) begin
            mreq = 1'b1; mline = nl; mage = 0;
            mdelay = $urandom_range(0, HF + HS + HB);
        end else if ((mreq && a) || stale) begin
            mreq = 1'b0;
        end else if (mreq) begin
            mage++;
        end
        if (wrap) mblank = und_now;
        if (wrap && ny == 0) marmed = 1'b1;
        mx = nx; my = ny; mfresh = 1'b0;
    endtask

    // Expected {hsync, vsync, active, env, frame_start, req, underrun} for POL=1.
    task automatic model_expect(output logic [6:0] e);
        if (mfresh) begin
            e = {5'b0, mreq, mund};
        end else begin
            e = {(mx >= HA + HF) && (mx < HA + HF + HS),
                 (my >= VA + VF) && (my < VA + VF + VS),
                 (mx < HA) && (my < VA) && !(BLANK_EN && mblank),
                 (mx == HT - 1),
                 (mx == 0) && (my == 0),
                 mreq, mund};
        end
    endtask

    // Reader behaviours: 0 tied high, 1 ack after 3 clocks, 2 withhold line 2,
    // 3 random delay, 4 never ack.
    function automatic bit ack_for(input int mode);
        case (mode)
            0: return 1'b1;
            1: return mreq && (mage >= 3);
            2: return mreq && (mline != 2);
            3: return mreq && (mage >= mdelay);
            default: return 1'b0;
        endcase
    endfunction

    task automatic tick(input bit e, input bit a);
        en = e; ack = a;
        @(posedge clk);
        if (e) model_step(a);
        #1;
    endtask

    task automatic run_to(input int x, input int y, input int mode);
        for (int i = 0; i < HT * VT && !(mx == x && my == y); i++) tick(1'b1, ack_for(mode));
    endtask

    task automatic test_stream(input int n, input int mode, input bit rand_en);
        logic [6:0] e;
        bit        ee;
        for (int i = 0; i < n; i++) begin
            ee = rand_en ? ($urandom_range(0, 9) != 0) : 1'b1;
            tick(ee, ack_for(mode));
            model_expect(e);
            checks++;
            if ({p_x, p_y, p_ln} !== {16'(mx), 16'(my), 16'(mline)}) begin
                errors++;
                $display("FAIL stream_pos: got x=%0d y=%0d ln=%0d want x=%0d y=%0d ln=%0d",
                         p_x, p_y, p_ln, mx, my, mline);
            end
            checks++;
            if ({p_hs, p_vs, p_act, p_env, p_fs, p_req, p_und} !== e) begin
                errors++;
                $display("FAIL stream_flags at (%0d,%0d): got %b want %b", mx, my,
                         {p_hs, p_vs, p_act, p_env, p_fs, p_req, p_und}, e);
            end
            checks++;
            if ({n_hs, n_vs, n_act, n_env, n_fs, n_req, n_und, n_x, n_y, n_ln} !==
                {~e[6:5], e[4:0], 16'(mx), 16'(my), 16'(mline)}) begin
                errors++;
                $display("FAIL stream_pol0 at (%0d,%0d): got %b want %b", mx, my,
                         {n_hs, n_vs, n_act, n_env, n_fs, n_req, n_und}, {~e[6:5], e[4:0]});
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; ack = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({p_hs, p_vs, p_act, p_env, p_fs, p_req, p_und, p_x, p_y, p_ln} !== 55'd0) begin
            errors++;
            $display("FAIL reset_pol1: got %b x=%0d y=%0d want all zero",
                     {p_hs, p_vs, p_act, p_env, p_fs, p_req, p_und}, p_x, p_y);
        end
        checks++;
        if ({n_hs, n_vs, n_act, n_env, n_fs, n_req, n_und} !== 7'b1100000) begin
            errors++;
            $display("FAIL reset_pol0: got %b want 1100000", {n_hs, n_vs, n_act, n_env, n_fs, n_req, n_und});
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) tick(1'b0, 1'b1);
        checks++;
        if ({p_act, p_env, p_fs, p_x, p_y} !== 35'd0) begin
            errors++;
            $display("FAIL reset_hold_en_low: got act=%b env=%b fs=%b x=%0d y=%0d want zeros",
                     p_act, p_env, p_fs, p_x, p_y);
        end
    endtask

    task automatic test_frame_period();
        int cnt = 0;
        for (int k = 1; k <= 2 * HT * VT; k++) begin
            tick(1'b1, ack_for(0));
            checks++;
            if ({p_hs, p_vs, p_env} !== {((k % HT) >= 10) && ((k % HT) <= 11),
                                         ((k / HT) % VT) == 5, (k % HT) == 13}) begin
                errors++;
                $display("FAIL sync_positions at k=%0d: got hs=%b vs=%b env=%b", k, p_hs, p_vs, p_env);
            end
            if (p_fs) begin
                checks++;
                if (k != (cnt + 1) * HT * VT) begin
                    errors++;
                    $display("FAIL frame_start_time: got clock %0d want %0d", k, (cnt + 1) * HT * VT);
                end
                cnt++;
            end
        end
        checks++;
        if (cnt != 2) begin
            errors++;
            $display("FAIL frame_start_count: got %0d want 2", cnt);
        end
    endtask

    task automatic test_ack_delay();
        int  exp_ln[4] = '{1, 2, 3, 0};
        int  exp_y[4]  = '{0, 1, 2, 6};
        int  nreq = 0;
        int  run = 0;
        bit  prev, counting;
        counting = 1'b0;
        run_to(0, 0, 0);
        prev = p_req;
        for (int i = 0; i < 2 * HT * VT; i++) begin
            tick(1'b1, ack_for(1));
            if (p_req && !prev) begin
                checks++;
                if (p_ln !== 16'(exp_ln[nreq % 4]) || p_y !== 16'(exp_y[nreq % 4]) || p_x !== 16'(HA)) begin
                    errors++;
                    $display("FAIL req_start: got ln=%0d y=%0d x=%0d want ln=%0d y=%0d x=%0d",
                             p_ln, p_y, p_x, exp_ln[nreq % 4], exp_y[nreq % 4], HA);
                end
                nreq++; run = 1; counting = 1'b1;
            end else if (p_req) begin
                run++;
            end else if (prev && counting) begin
                checks++;
                if (run != 4) begin
                    errors++;
                    $display("FAIL req_length: got %0d clocks want 4", run);
                end
                counting = 1'b0;
            end
            prev = p_req;
        end
        checks++;
        if (nreq != 8) begin
            errors++;
            $display("FAIL req_count: got %0d want 8", nreq);
        end
        checks++;
        if (p_und !== 1'b0) begin
            errors++;
            $display("FAIL no_underrun_with_delay: got %b want 0", p_und);
        end
    endtask

    task automatic test_underrun();
        run_to(0, 0, 0);
        run_to(0, 2, 2);
        checks++;
        if ({p_y, p_und, p_req, p_act} !== {16'd2, 1'b1, 1'b0, !BLANK_EN}) begin
            errors++;
            $display("FAIL underrun_wrap: got y=%0d und=%b req=%b act=%b want y=2 und=1 req=0 act=%b",
                     p_y, p_und, p_req, p_act, !BLANK_EN);
        end
        for (int i = 1; i < HT; i++) begin
            tick(1'b1, ack_for(2));
            checks++;
            if (p_act !== ((i < HA) && !BLANK_EN)) begin
                errors++;
                $display("FAIL underrun_line_active at x=%0d: got %b want %b", i, p_act, (i < HA) && !BLANK_EN);
            end
        end
        test_stream(HT * VT, 0, 1'b0);
    endtask

    task automatic test_reset_mid();
        run_to(10, 2, 4);
        checks++;
        if ({p_req, p_ln} !== {1'b1, 16'd3}) begin
            errors++;
            $display("FAIL pending_before_reset: got req=%b ln=%0d want req=1 ln=3", p_req, p_ln);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({p_hs, p_vs, p_act, p_env, p_fs, p_req, p_und, p_x, p_y, p_ln} !== 55'd0 ||
            {n_hs, n_vs, n_req, n_und} !== 4'b1100) begin
            errors++;
            $display("FAIL async_reset: got %b x=%0d y=%0d ln=%0d",
                     {p_hs, p_vs, p_act, p_env, p_fs, p_req, p_und}, p_x, p_y, p_ln);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        test_stream(HT * VT + HT, 2, 1'b0);
        checks++;
        if (p_und !== 1'b0) begin
            errors++;
            $display("FAIL first_frame_unarmed: got und=%b want 0", p_und);
        end
    endtask

    task automatic test_enable_hold();
        int cnt;
        run_to(HT - 1, 3, 0);
        cnt = p_env ? 1 : 0;
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, 1'b1);
            if (p_env) cnt++;
            checks++;
            if ({p_x, p_y, p_env} !== {16'(HT - 1), 16'd3, 1'b1}) begin
                errors++;
                $display("FAIL enable_hold: got x=%0d y=%0d env=%b want x=%0d y=3 env=1",
                         p_x, p_y, p_env, HT - 1);
            end
        end
        tick(1'b1, 1'b1);
        checks++;
        if (cnt != 6 || {p_env, p_x, p_y} !== {1'b0, 16'd0, 16'd4}) begin
            errors++;
            $display("FAIL enable_release: got env_clocks=%0d env=%b x=%0d y=%0d want 6 0 0 4",
                     cnt, p_env, p_x, p_y);
        end
    endtask

    initial begin
        test_reset();
        test_frame_period();
        test_stream(2 * HT * VT, 0, 1'b0);
        test_ack_delay();
        test_underrun();
        test_reset_mid();
        test_enable_hold();
        test_stream(1000, 3, 1'b1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
